user_id_bank: RTL and testbench

USER_ID_BANK -- requirements
Module: user_id_bank

---
 rtl/user_id_pkg.sv | 17 +
 rtl/scl_conb.sv | 11 +
 rtl/user_id_const_word.sv | 21 ++
 rtl/user_id_bank.sv | 164 ++++++++++++++++
 tb/tb_user_id_bank.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/user_id_pkg.sv
// Shared types and helpers for the user ID bank: serial dump FSM states and
// the width helper used for index, bit and phase counters.
package user_id_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } ser_state_t;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int width_for(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scl_conb.sv
// Behavioural model of the standard-cell tie cell: one constant-high and one
// constant-low output. Replaced by the library cell at implementation.
module scl_conb (
  output logic HI,
  output logic LO
);

  assign HI = 1'b1;
  assign LO = 1'b0;

endmodule

// File: rtl/user_id_const_word.sv
// One ID word built purely from tie cells. Each bit gets its own scl_conb so the
// value can be changed late by a metal-only edit of the selected tie output.
module user_id_const_word #(
  parameter int                    WORD_WIDTH = 32,
  parameter logic [WORD_WIDTH-1:0] VALUE      = '0
) (
  output logic [WORD_WIDTH-1:0] word
);

  logic [WORD_WIDTH-1:0] tie_hi;
  logic [WORD_WIDTH-1:0] tie_lo;

  for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_bit
    scl_conb u_conb (
      .HI(tie_hi[i]),
      .LO(tie_lo[i])
    );
    assign word[i] = VALUE[i] ? tie_hi[i] : tie_lo[i];
  end

endmodule

// File: rtl/user_id_bank.sv
// User ID bank: constant ID words readable one word at a time over a simple
// request/ack port, plus an independent serial dump of all words (word 0
// first, MSB first) with a divided bit clock.
module user_id_bank
  import user_id_pkg::*;
#(
  parameter int                                NUM_WORDS     = 4,
  parameter int                                WORD_WIDTH    = 32,
  parameter logic [NUM_WORDS*WORD_WIDTH-1:0]   USER_ID_VALUE = '0,
  parameter int                                SER_DIV       = 4
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic                              rd_req_i,
  input  logic [width_for(NUM_WORDS)-1:0]   rd_idx_i,
  output logic                              rd_ack_o,
  output logic [WORD_WIDTH-1:0]             rd_data_o,
  output logic                              rd_err_o,
  input  logic                              ser_start_i,
  output logic                              ser_busy_o,
  output logic                              ser_clk_o,
  output logic                              ser_dat_o,
  output logic                              ser_done_o,
  output logic [WORD_WIDTH-1:0]             mask_rev
);

  localparam int IDXW       = width_for(NUM_WORDS);
  localparam int TOTAL_BITS = NUM_WORDS * WORD_WIDTH;
  localparam int BW         = width_for(TOTAL_BITS);
  localparam int PW         = width_for(SER_DIV);

  localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL_BITS - 1);
  localparam logic [PW-1:0] PH_LAST  = PW'(SER_DIV - 1);
  // Phase after which the bit clock rises for the second half of the period.
  localparam logic [PW-1:0] PH_RISE  = PW'(SER_DIV / 2 - 1);

  logic [WORD_WIDTH-1:0] id_word [NUM_WORDS];
  // Serial image arranged so that bit TOTAL_BITS-1 is word 0's MSB; the bit
  // counter then simply counts down through it.
  logic [TOTAL_BITS-1:0] ser_vec;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    user_id_const_word #(
      .WORD_WIDTH(WORD_WIDTH),
      .VALUE     (USER_ID_VALUE[k*WORD_WIDTH +: WORD_WIDTH])
    ) u_word (
      .word(id_word[k])
    );
    assign ser_vec[(NUM_WORDS-1-k)*WORD_WIDTH +: WORD_WIDTH] = id_word[k];
  end

  assign mask_rev = id_word[0];

  // ---------------------------------------------------------------------
  // Parallel read path
  // ---------------------------------------------------------------------
  logic [WORD_WIDTH-1:0] rd_word;
  logic                  rd_oob;

  assign rd_oob = (32'(rd_idx_i) >= 32'(NUM_WORDS));

  // Word select mux over the tie-cell words.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (rd_idx_i == IDXW'(k)) rd_word = id_word[k];
    end
  end

  // Register the read response one cycle after the request; data holds between acks.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rd_ack_o  <= 1'b0;
      rd_err_o  <= 1'b0;
      rd_data_o <= '0;
    end else begin
      rd_ack_o <= rd_req_i;
      rd_err_o <= rd_req_i & rd_oob;
      if (rd_req_i) rd_data_o <= rd_oob ? '0 : rd_word;
    end
  end

  // ---------------------------------------------------------------------
  // Serial dump
  // ---------------------------------------------------------------------
  ser_state_t    state, state_nxt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic [PW-1:0] phase_cnt, phase_nxt;
  logic          clk_nxt;
  logic          dat_nxt;

  // Serial FSM state, counters and the registered bit clock/data outputs.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      phase_cnt <= '0;
      ser_clk_o <= 1'b0;
      ser_dat_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_nxt;
      phase_cnt <= phase_nxt;
      ser_clk_o <= clk_nxt;
      ser_dat_o <= dat_nxt;
    end
  end

  // Next-state logic; clock and data are computed one cycle ahead so they are glitch-free flops.
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_cnt;
    phase_nxt = phase_cnt;
    clk_nxt   = ser_clk_o;
    dat_nxt   = ser_dat_o;
    case (state)
      IDLE: begin
        clk_nxt = 1'b0;
        dat_nxt = 1'b0;
        if (ser_start_i) begin
          state_nxt = LOAD;
          bit_nxt   = BIT_LAST;
          phase_nxt = '0;
        end
      end
      LOAD: begin
        state_nxt = SHIFT;
        phase_nxt = '0;
        clk_nxt   = 1'b0;
        dat_nxt   = ser_vec[bit_cnt];
      end
      SHIFT: begin
        if (phase_cnt == PH_LAST) begin
          phase_nxt = '0;
          clk_nxt   = 1'b0;
          if (bit_cnt == '0) begin
            state_nxt = DONE;
            dat_nxt   = 1'b0;
          end else begin
            bit_nxt = bit_cnt - BW'(1);
            dat_nxt = ser_vec[bit_nxt];
          end
        end else begin
          phase_nxt = phase_cnt + PW'(1);
          if (phase_cnt == PH_RISE) clk_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        clk_nxt   = 1'b0;
        dat_nxt   = 1'b0;
      end
      default: begin
        state_nxt = IDLE;
        clk_nxt   = 1'b0;
        dat_nxt   = 1'b0;
      end
    endcase
  end

  assign ser_busy_o = (state == LOAD) || (state == SHIFT);
  assign ser_done_o = (state == DONE);

endmodule

// File: tb/tb_user_id_bank.sv
// Self-checking bench for user_id_bank: a 2x8 instance carries the read,
// serial, reset and concurrency scenarios; a 3x8 instance covers the
// out-of-range index case.
module tb_user_id_bank;

  localparam int NW      = 2;
  localparam int WW      = 8;
  localparam int SD      = 4;
  localparam int TOT     = NW * WW;
  localparam int DONE_AT = 2 + TOT * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rd_req = 1'b0;
  logic [0:0] rd_idx = '0;
  logic       ser_start = 1'b0;
  logic       rd_ack, rd_err, ser_busy, ser_clk, ser_dat, ser_done;
  logic [7:0] rd_data, mask;

  logic       rd_req3 = 1'b0;
  logic [1:0] rd_idx3 = '0;
  logic       ser_start3 = 1'b0;
  logic       rd_ack3, rd_err3, ser_busy3, ser_clk3, ser_dat3, ser_done3;
  logic [7:0] rd_data3, mask3;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  exp_word [0:2] = '{8'h5A, 8'hA5, 8'hC3};
  logic [15:0] exp_stream = 16'b0101_1010_1010_0101;

  logic [8:0] q_rd [$];
  logic [8:0] q_rd3 [$];
  logic       ser_q [$];

  user_id_bank #(
    .NUM_WORDS(NW), .WORD_WIDTH(WW), .USER_ID_VALUE(16'hA55A), .SER_DIV(SD)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_ack_o(rd_ack),
    .rd_data_o(rd_data), .rd_err_o(rd_err),
    .ser_start_i(ser_start), .ser_busy_o(ser_busy), .ser_clk_o(ser_clk),
    .ser_dat_o(ser_dat), .ser_done_o(ser_done), .mask_rev(mask)
  );

  user_id_bank #(
    .NUM_WORDS(3), .WORD_WIDTH(WW), .USER_ID_VALUE(24'hC3A55A), .SER_DIV(SD)
  ) dut3 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .rd_req_i(rd_req3), .rd_idx_i(rd_idx3), .rd_ack_o(rd_ack3),
    .rd_data_o(rd_data3), .rd_err_o(rd_err3),
    .ser_start_i(ser_start3), .ser_busy_o(ser_busy3), .ser_clk_o(ser_clk3),
    .ser_dat_o(ser_dat3), .ser_done_o(ser_done3), .mask_rev(mask3)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rd_ack, rd_err, rd_data, ser_busy, ser_clk, ser_dat, ser_done} !== 14'h0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs got %b required 0",
               {rd_ack, rd_err, rd_data, ser_busy, ser_clk, ser_dat, ser_done});
    end
    n_cmp++;
    if (mask !== 8'h5A) begin
      n_err++;
      $display("[TB] FAIL reset_mask_rev got %h required 5a", mask);
    end
    n_cmp++;
    if ({rd_ack3, rd_err3, rd_data3, ser_busy3, ser_clk3, ser_dat3, ser_done3} !== 14'h0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs3 got %b required 0",
               {rd_ack3, rd_err3, rd_data3, ser_busy3, ser_clk3, ser_dat3, ser_done3});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({rd_ack, ser_busy, ser_done, mask3} !== {3'b000, 8'h5A}) begin
      n_err++;
      $display("[TB] FAIL post_reset_idle got %b required %b",
               {rd_ack, ser_busy, ser_done, mask3}, {3'b000, 8'h5A});
    end
  endtask

  task automatic test_read();
    logic [1:0] tbl  [0:7] = '{2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11, 2'b11, 2'b00};
    logic [2:0] tbl3 [0:7] = '{3'b111, 3'b110, 3'b100, 3'b000, 3'b111, 3'b101, 3'b000, 3'b000};
    logic [8:0] e;
    logic [7:0] last = 8'h00;
    logic [7:0] last3 = 8'h00;
    logic       prev = 1'b0;
    logic       prev3 = 1'b0;
    int         ix;
    q_rd.delete();
    q_rd3.delete();
    for (int i = 0; i <= 8; i++) begin
      n_cmp++;
      if (rd_ack !== prev) begin
        n_err++;
        $display("[TB] FAIL read_ack_timing step %0d got %b required %b", i, rd_ack, prev);
      end
      n_cmp++;
      if (rd_ack) begin
        if (q_rd.size() == 0) begin
          n_err++;
          $display("[TB] FAIL read_unexpected_ack got ack required none");
        end else begin
          e = q_rd.pop_front();
          last = e[7:0];
          if ({rd_err, rd_data} !== e) begin
            n_err++;
            $display("[TB] FAIL read_data step %0d got %h required %h", i, {rd_err, rd_data}, e);
          end
        end
      end else if (rd_data !== last) begin
        n_err++;
        $display("[TB] FAIL read_hold step %0d got %h required %h", i, rd_data, last);
      end
      n_cmp++;
      if (rd_ack3 !== prev3) begin
        n_err++;
        $display("[TB] FAIL read3_ack_timing step %0d got %b required %b", i, rd_ack3, prev3);
      end
      n_cmp++;
      if (rd_ack3) begin
        if (q_rd3.size() == 0) begin
          n_err++;
          $display("[TB] FAIL read3_unexpected_ack got ack required none");
        end else begin
          e = q_rd3.pop_front();
          last3 = e[7:0];
          if ({rd_err3, rd_data3} !== e) begin
            n_err++;
            $display("[TB] FAIL read3_data step %0d got %h required %h", i, {rd_err3, rd_data3}, e);
          end
        end
      end else if (rd_data3 !== last3) begin
        n_err++;
        $display("[TB] FAIL read3_hold step %0d got %h required %h", i, rd_data3, last3);
      end
      if (i < 8) begin
        rd_req  = tbl[i][1];
        rd_idx  = tbl[i][0];
        rd_req3 = tbl3[i][2];
        rd_idx3 = tbl3[i][1:0];
        if (rd_req) q_rd.push_back({1'b0, exp_word[int'(tbl[i][0])]});
        if (rd_req3) begin
          ix = int'(tbl3[i][1:0]);
          if (ix < 3) q_rd3.push_back({1'b0, exp_word[ix]});
          else        q_rd3.push_back({1'b1, 8'h00});
        end
      end else begin
        rd_req  = 1'b0;
        rd_req3 = 1'b0;
      end
      prev  = rd_req;
      prev3 = rd_req3;
      @(negedge clk);
    end
    n_cmp++;
    if (q_rd.size() + q_rd3.size() != 0) begin
      n_err++;
      $display("[TB] FAIL read_missing_acks got %0d pending required 0", q_rd.size() + q_rd3.size());
    end
  endtask

  task automatic test_serial_dump(input string tag, input int extra_at, input bit with_reads);
    logic       prev_clk = 1'b0;
    logic       prev_req = 1'b0;
    logic       eb;
    logic [8:0] e;
    int         done_cnt = 0;
    int         done_at = -1;
    ser_q.delete();
    q_rd.delete();
    for (int i = 0; i < TOT; i++) ser_q.push_back(exp_stream[TOT-1-i]);
    ser_start = 1'b1;
    if (with_reads) begin
      rd_req = 1'b1;
      rd_idx = 1'b0;
      q_rd.push_back({1'b0, exp_word[0]});
      prev_req = 1'b1;
    end
    for (int c = 1; c <= DONE_AT + 3; c++) begin
      @(negedge clk);
      ser_start = (c == extra_at);
      if (c == 1) begin
        n_cmp++;
        if (ser_busy !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL %s load_busy got %b required 1", tag, ser_busy);
        end
      end
      if (ser_clk && !prev_clk) begin
        n_cmp++;
        if (ser_q.size() == 0) begin
          n_err++;
          $display("[TB] FAIL %s ser_extra_bit at cycle %0d got edge required none", tag, c);
        end else begin
          eb = ser_q.pop_front();
          if (ser_dat !== eb) begin
            n_err++;
            $display("[TB] FAIL %s ser_bit %0d got %b required %b", tag, TOT-1-ser_q.size(), ser_dat, eb);
          end
        end
      end
      prev_clk = ser_clk;
      if (ser_done) begin
        done_cnt++;
        done_at = c;
        n_cmp++;
        if ({ser_busy, ser_clk, ser_dat} !== 3'b000) begin
          n_err++;
          $display("[TB] FAIL %s done_outputs got %b required 000", tag, {ser_busy, ser_clk, ser_dat});
        end
      end
      if (with_reads) begin
        n_cmp++;
        if (rd_ack !== prev_req) begin
          n_err++;
          $display("[TB] FAIL %s concurrent_ack cycle %0d got %b required %b", tag, c, rd_ack, prev_req);
        end
        if (rd_ack && q_rd.size() != 0) begin
          e = q_rd.pop_front();
          n_cmp++;
          if ({rd_err, rd_data} !== e) begin
            n_err++;
            $display("[TB] FAIL %s concurrent_data cycle %0d got %h required %h", tag, c, {rd_err, rd_data}, e);
          end
        end
        if (c < DONE_AT) begin
          rd_req = 1'b1;
          rd_idx = 1'(c % 2);
          q_rd.push_back({1'b0, exp_word[c % 2]});
        end else begin
          rd_req = 1'b0;
        end
        prev_req = rd_req;
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != DONE_AT) begin
      n_err++;
      $display("[TB] FAIL %s done_timing got %0d pulses at %0d required 1 at %0d", tag, done_cnt, done_at, DONE_AT);
    end
    n_cmp++;
    if (ser_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL %s ser_bits_missing got %0d left required 0", tag, ser_q.size());
    end
    n_cmp++;
    if ({ser_busy, ser_clk, ser_dat, mask} !== {3'b000, 8'h5A}) begin
      n_err++;
      $display("[TB] FAIL %s end_idle got %b required %b", tag, {ser_busy, ser_clk, ser_dat, mask}, {3'b000, 8'h5A});
    end
    if (with_reads) begin
      n_cmp++;
      if (q_rd.size() != 0) begin
        n_err++;
        $display("[TB] FAIL %s concurrent_missing got %0d pending required 0", tag, q_rd.size());
      end
    end
  endtask

  task automatic test_serial();
    test_serial_dump("serial", 0, 1'b0);
  endtask

  task automatic test_start_ignored();
    test_serial_dump("start_ignored", 20, 1'b0);
  endtask

  task automatic test_reset_mid_shift();
    ser_start = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      ser_start = 1'b0;
      rd_req = (c == 35);
      rd_idx = 1'b1;
    end
    rd_req = 1'b0;
    n_cmp++;
    if ({ser_busy, ser_clk, ser_dat, rd_ack, rd_data} !== {3'b11, exp_stream[TOT-1-8], 1'b1, exp_word[1]}) begin
      n_err++;
      $display("[TB] FAIL pre_abort_state got %b required %b", {ser_busy, ser_clk, ser_dat, rd_ack, rd_data},
               {2'b11, exp_stream[TOT-1-8], 1'b1, exp_word[1]});
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({rd_ack, rd_err, rd_data, ser_busy, ser_clk, ser_dat, ser_done} !== 14'h0) begin
      n_err++;
      $display("[TB] FAIL async_reset_outputs got %b required 0",
               {rd_ack, rd_err, rd_data, ser_busy, ser_clk, ser_dat, ser_done});
    end
    n_cmp++;
    if (mask !== 8'h5A) begin
      n_err++;
      $display("[TB] FAIL async_reset_mask got %h required 5a", mask);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({ser_done, ser_busy} !== 2'b00) begin
        n_err++;
        $display("[TB] FAIL abort_no_done got %b required 00", {ser_done, ser_busy});
      end
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ser_done, ser_busy, ser_clk, ser_dat} !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL after_release_idle got %b required 0000", {ser_done, ser_busy, ser_clk, ser_dat});
    end
    test_serial_dump("restart", 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_serial_dump("back_to_back", 0, 1'b1);
  endtask

  initial begin
    $display("[TB] user_id_bank bench starting");
    test_reset();
    test_read();
    test_serial();
    test_start_ignored();
    test_reset_mid_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
